// File: rtl/lane_offset_scroller.sv
// lane_offset_scroller: per-lane vertical scroll offsets advanced on a
// prescaled tick, with wrap pulses and a saturating miss counter.
module lane_offset_scroller #(
    parameter int          NUM_LANES  = 4,
    parameter int          OFFSET_W   = 6,
    parameter int          MAX_OFFSET = 59,
    parameter int          DIV_W      = 20,
    parameter int          STEP_W     = 3,
    parameter logic [5:0]  IDLE_STATE = 6'd0,
    parameter int          MISS_W     = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic [5:0]                    current_state,
    input  logic                          edge_go,
    input  logic                          pause,
    input  logic [NUM_LANES-1:0]          lane_en,
    input  logic [NUM_LANES-1:0]          lane_clear,
    input  logic [STEP_W-1:0]             step,
    input  logic [DIV_W-1:0]              div_max,
    output logic [NUM_LANES*OFFSET_W-1:0] offset,
    output logic [NUM_LANES-1:0]          lane_wrap,
    output logic                          tick,
    output logic [MISS_W-1:0]             miss_count
);

    localparam logic [OFFSET_W:0] MAX_X  = (OFFSET_W+1)'(MAX_OFFSET);
    localparam logic [OFFSET_W:0] WRAP_X = (OFFSET_W+1)'(MAX_OFFSET + 1);

    logic [OFFSET_W-1:0] off_q [NUM_LANES];
    logic [OFFSET_W-1:0] off_d [NUM_LANES];
    logic [OFFSET_W:0]   lane_sum [NUM_LANES];
    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic                tick_q, tick_d;
    logic [NUM_LANES-1:0] wrap_q, wrap_d;
    logic [MISS_W-1:0]   miss_q, miss_d;
    logic [MISS_W:0]     pop, msum;
    logic                clr, tick_int;

    assign clr      = start && (current_state == IDLE_STATE);
    assign tick_int = (cnt_q == div_max);

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_sum[i] = {1'b0, off_q[i]}
                        + {{(OFFSET_W+1-STEP_W){1'b0}}, step};
        end
    end

    always_comb begin
        off_d  = off_q;
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        wrap_d = '0;
        miss_d = miss_q;
        pop    = '0;
        msum   = '0;
        if (clr) begin
            off_d  = '{default: '0};
            cnt_d  = '0;
            miss_d = '0;
        end else if (edge_go) begin
            off_d = '{default: '0};
            cnt_d = '0;
        end else if (!pause) begin
            cnt_d  = tick_int ? '0 : cnt_q + DIV_W'(1);
            tick_d = tick_int;
            for (int i = 0; i < NUM_LANES; i++) begin
                if (lane_clear[i]) begin
                    off_d[i] = '0;
                end else if (tick_int && lane_en[i]) begin
                    if (lane_sum[i] > MAX_X) begin
                        off_d[i]  = OFFSET_W'(lane_sum[i] - WRAP_X);
                        wrap_d[i] = 1'b1;
                    end else begin
                        off_d[i] = lane_sum[i][OFFSET_W-1:0];
                    end
                end
            end
            // several lanes can wrap together; each one counts as a miss
            for (int i = 0; i < NUM_LANES; i++) begin
                pop = pop + {{MISS_W{1'b0}}, wrap_d[i]};
            end
            msum   = {1'b0, miss_q} + pop;
            miss_d = msum[MISS_W] ? '1 : msum[MISS_W-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            off_q  <= '{default: '0};
            cnt_q  <= '0;
            tick_q <= 1'b0;
            wrap_q <= '0;
            miss_q <= '0;
        end else begin
            off_q  <= off_d;
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            wrap_q <= wrap_d;
            miss_q <= miss_d;
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_out
        assign offset[g*OFFSET_W +: OFFSET_W] = off_q[g];
    end

    assign lane_wrap  = wrap_q;
    assign tick       = tick_q;
    assign miss_count = miss_q;

endmodule

// File: tb/tb_lane_offset_scroller.sv
// Bench for lane_offset_scroller: directed scenarios then random traffic,
// each cycle compared against an arithmetic model of the lane rules.
module tb_lane_offset_scroller;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  current_state = 6'd0;
    logic        edge_go = 1'b0;
    logic        pause = 1'b0;
    logic [3:0]  lane_en = 4'b0;
    logic [3:0]  lane_clear = 4'b0;
    logic [2:0]  step = 3'd0;
    logic [19:0] div_max = 20'd3;
    logic [23:0] offset;
    logic [3:0]  lane_wrap;
    logic        tick;
    logic [7:0]  miss_count;

    int errors = 0;
    int checks = 0;

    int m_off [4];
    int m_cnt;
    int m_tick;
    int m_wrap [4];
    int m_miss;

    lane_offset_scroller dut (
        .clock(clock), .reset(reset), .start(start),
        .current_state(current_state), .edge_go(edge_go),
        .pause(pause), .lane_en(lane_en), .lane_clear(lane_clear),
        .step(step), .div_max(div_max), .offset(offset),
        .lane_wrap(lane_wrap), .tick(tick), .miss_count(miss_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0t observed=%0h expected=%0h",
                   tag, $time, obs, exp);
        end
    endtask

    task automatic model_step();
        int wraps;
        if (reset || (start && current_state == 6'd0)) begin
            for (int i = 0; i < 4; i++) begin
                m_off[i] = 0;
                m_wrap[i] = 0;
            end
            m_cnt = 0; m_tick = 0; m_miss = 0;
        end else if (edge_go) begin
            for (int i = 0; i < 4; i++) begin
                m_off[i] = 0;
                m_wrap[i] = 0;
            end
            m_cnt = 0; m_tick = 0;
        end else if (pause) begin
            for (int i = 0; i < 4; i++) m_wrap[i] = 0;
            m_tick = 0;
        end else begin
            m_tick = (m_cnt == int'(div_max)) ? 1 : 0;
            m_cnt = m_tick ? 0 : (m_cnt + 1) % (1 << 20);
            wraps = 0;
            for (int i = 0; i < 4; i++) begin
                m_wrap[i] = 0;
                if (lane_clear[i]) begin
                    m_off[i] = 0;
                end else if (m_tick == 1 && lane_en[i]) begin
                    m_wrap[i] = (m_off[i] + int'(step) >= 60) ? 1 : 0;
                    m_off[i] = (m_off[i] + int'(step)) % 60;
                end
                wraps += m_wrap[i];
            end
            m_miss = (m_miss + wraps > 255) ? 255 : m_miss + wraps;
        end
    endtask

    function automatic logic [31:0] exp_offset();
        logic [31:0] v = 0;
        for (int i = 0; i < 4; i++) v = v + (m_off[i] << (6 * i));
        return v;
    endfunction

    function automatic logic [31:0] exp_wrap();
        logic [31:0] v = 0;
        for (int i = 0; i < 4; i++) v = v + (m_wrap[i] << i);
        return v;
    endfunction

    task automatic cyc();
        @(posedge clock);
        model_step();
        #1;
        chk("offset", 32'(offset), exp_offset());
        chk("lane_wrap", 32'(lane_wrap), exp_wrap());
        chk("tick", 32'(tick), 32'(m_tick));
        chk("miss_count", 32'(miss_count), 32'(m_miss));
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic go_pulse(input logic [19:0] dm);
        edge_go = 1'b1;
        div_max = dm;
        cyc();
        edge_go = 1'b0;
    endtask

    initial begin
        // reset, then free running with div_max=3
        run(2);
        chk("reset_offset", 32'(offset), 32'd0);
        chk("reset_miss", 32'(miss_count), 32'd0);
        reset = 1'b0;
        current_state = 6'd3;
        step = 3'd1;
        lane_en = 4'b1111;
        run(4);
        chk("first_tick", 32'(tick), 32'd1);
        chk("first_adv", 32'(offset), 32'h041041);
        run(20);

        // lane 0 walks to 58 then wraps with step 3
        lane_en = 4'b0001;
        step = 3'd2;
        go_pulse(20'd0);
        run(29);
        chk("lane0_58", 32'(offset), 32'd58);
        step = 3'd3;
        cyc();
        chk("lane0_wrap_off", 32'(offset), 32'd1);
        chk("lane0_wrap", 32'(lane_wrap), 32'b0001);

        // all lanes to 59 then wrap together
        lane_en = 4'b1111;
        step = 3'd1;
        go_pulse(20'd0);
        run(59);
        cyc();
        chk("all_wrap", 32'(lane_wrap), 32'b1111);
        chk("all_wrap_off", 32'(offset), 32'd0);

        // saturate the miss counter
        step = 3'd7;
        run(800);
        chk("miss_sat", 32'(miss_count), 32'd255);

        // clear coincident with a tick on lane 1
        step = 3'd1;
        go_pulse(20'd0);
        run(59);
        lane_clear = 4'b0010;
        cyc();
        lane_clear = 4'b0000;
        chk("clr_lane_wrap", 32'(lane_wrap), 32'b1101);
        chk("clr_lane_off", 32'(offset), 32'd0);

        // pause mid-run, then edge_go
        go_pulse(20'd3);
        run(10);
        pause = 1'b1;
        run(10);
        pause = 1'b0;
        run(7);
        go_pulse(20'd3);
        chk("edge_go_off", 32'(offset), 32'd0);

        // start outside and inside the idle state
        run(9);
        start = 1'b1;
        current_state = 6'd5;
        cyc();
        current_state = 6'd0;
        cyc();
        start = 1'b0;
        current_state = 6'd2;
        chk("clr_miss", 32'(miss_count), 32'd0);
        chk("clr_off", 32'(offset), 32'd0);

        // random traffic
        for (int k = 0; k < 3000; k++) begin
            reset = ($urandom % 500) == 0;
            start = ($urandom % 50) == 0;
            current_state = 6'($urandom % 4);
            edge_go = ($urandom % 40) == 0;
            if (edge_go) div_max = 20'($urandom % 4);
            pause = ($urandom % 10) == 0;
            lane_en = 4'($urandom);
            lane_clear = (($urandom % 8) == 0) ? 4'($urandom) : 4'b0;
            step = 3'($urandom);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
